// File: rtl/uart_cmd_pkg.sv
// Shared constants and encodings for the UART command responder.
// MAX_REPLY_LEN grows by one when UART_CMD_ERRCNT_EN is defined.
package uart_cmd_pkg;

   localparam logic [7:0] OP_CAR  = 8'h43;
   localparam logic [7:0] OP_UP   = 8'h55;
   localparam logic [7:0] OP_DOWN = 8'h44;
   localparam logic [7:0] OP_STAT = 8'h53;
   localparam logic [7:0] ACK     = 8'h4B;
   localparam logic [7:0] ERR     = 8'h45;
   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] DIR_I   = 8'h49;
   localparam logic [7:0] DIR_U   = 8'h55;
   localparam logic [7:0] DIR_D   = 8'h44;
   localparam logic [7:0] HEALTH_OK = 8'h4F;

`ifdef UART_CMD_ERRCNT_EN
   localparam int MAX_REPLY_LEN = 5;
`else
   localparam int MAX_REPLY_LEN = 4;
`endif
   localparam int LEN_W = 3;

   typedef enum logic [1:0] {
      CMD_CAR  = 2'b00,
      CMD_UP   = 2'b01,
      CMD_DOWN = 2'b10
   } cmd_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ARG,
      ST_GET_TERM,
      ST_EXEC,
      ST_REPLY
   } state_e;

   typedef enum logic [1:0] {
      TS_IDLE,
      TS_BYTE,
      TS_WAIT
   } tx_state_e;

   typedef enum logic [1:0] {
      RK_ACK,
      RK_STAT,
      RK_ERR
   } reply_e;

   // 2'b11 is not a legal direction; report it as idle
   function automatic logic [7:0] dir_char(input logic [1:0] dir);
      case (dir)
         2'b01:   return DIR_U;
         2'b10:   return DIR_D;
         default: return DIR_I;
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Reply buffer and byte sequencer for the UART sender en/ready handshake.
//   state   | meaning
//   TS_IDLE | no reply pending, accepts a load
//   TS_BYTE | waiting for sender ready, then pulses tx_en
//   TS_WAIT | waiting for ready to drop before moving on
module uart_cmd_tx_seq
   import uart_cmd_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_load,
   input  logic [MAX_REPLY_LEN-1:0][7:0] i_bytes,
   input  logic [LEN_W-1:0]              i_len,
   input  logic                          i_tx_ready,
   output logic [7:0]                    o_tx_data,
   output logic                          o_tx_en,
   output logic                          o_busy
);
   localparam int IDX_W = $clog2(MAX_REPLY_LEN);

   tx_state_e                     r_state, w_next;
   logic [MAX_REPLY_LEN-1:0][7:0] r_buf;
   logic [LEN_W-1:0]              r_len;
   logic [IDX_W-1:0]              r_idx;
   logic                          r_tx_en;
   logic [7:0]                    r_tx_data;
   logic                          w_fire, w_adv, w_last;

   assign w_last = (LEN_W'(r_idx) == r_len - LEN_W'(1));

   always_comb begin
      w_next = r_state;
      w_fire = 1'b0;
      w_adv  = 1'b0;
      case (r_state)
         TS_IDLE: if (i_load) w_next = TS_BYTE;
         TS_BYTE: if (i_tx_ready) begin
            w_fire = 1'b1;
            w_next = TS_WAIT;
         end
         // ready still high on the tx_en cycle must not count as a new grant
         TS_WAIT: if (!i_tx_ready) begin
            w_adv  = 1'b1;
            w_next = w_last ? TS_IDLE : TS_BYTE;
         end
         default: w_next = TS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= TS_IDLE;
         r_buf     <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= 8'hFF;
      end else begin
         r_state <= w_next;
         r_tx_en <= w_fire;
         if (w_fire) r_tx_data <= r_buf[r_idx];
         if (w_adv)  r_idx <= r_idx + IDX_W'(1);
         if (r_state == TS_IDLE && i_load) begin
            r_buf <= i_bytes;
            r_len <= i_len;
            r_idx <= '0;
         end
      end
   end

   assign o_tx_en   = r_tx_en;
   assign o_tx_data = r_tx_data;
   assign o_busy    = (r_state != TS_IDLE);

endmodule

// File: rtl/uart_cmd_responder.sv
// UART command endpoint: parses OP,ARG,CR frames, strobes floor calls, answers every frame.
// UART_CMD_ERRCNT_EN adds the err_count port and a health byte in the status reply.
//   state       | meaning
//   ST_IDLE     | waiting for opcode byte
//   ST_GET_ARG  | waiting for argument byte, inter-byte timeout armed
//   ST_GET_TERM | waiting for terminator, inter-byte timeout armed
//   ST_EXEC     | reply loaded into sequencer, command strobe out
//   ST_REPLY    | reply draining, received bytes dropped
module uart_cmd_responder
   import uart_cmd_pkg::*;
#(
   parameter int CLKFRQ        = 100000000,
   parameter int BAUDRATE      = 9600,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   input  logic [2:0] cur_floor,
   input  logic [1:0] cur_dir,
   output logic       cmd_valid,
   output logic [1:0] cmd_type,
`ifdef UART_CMD_ERRCNT_EN
   output logic [7:0] err_count,
`endif
   output logic [2:0] cmd_floor
);
   localparam logic [23:0] TMO_LIMIT = 24'((CLKFRQ / BAUDRATE) * 10 * TIMEOUT_BYTES);

   state_e                        r_state, w_next;
   logic [7:0]                    r_op, r_arg;
   logic [23:0]                   r_tmo_cnt;
   reply_e                        r_kind;
   logic                          r_cmd_valid;
   logic [1:0]                    r_cmd_type;
   logic [2:0]                    r_cmd_floor;
   logic                          w_in_frame, w_timeout, w_frame_ok, w_busy, w_load;
   cmd_type_e                     w_cmd_type;
   logic [MAX_REPLY_LEN-1:0][7:0] w_bytes;
   logic [LEN_W-1:0]              w_len;

   assign w_in_frame = (r_state == ST_GET_ARG) || (r_state == ST_GET_TERM);
   assign w_timeout  = w_in_frame && (r_tmo_cnt >= TMO_LIMIT);
   assign w_load     = (r_state == ST_EXEC);

   // frame check, evaluated against the byte arriving in ST_GET_TERM
   always_comb begin
      w_frame_ok = 1'b0;
      w_cmd_type = CMD_CAR;
      case (r_op)
         OP_CAR:  w_frame_ok = (r_arg >= 8'h31) && (r_arg <= 8'h37);
         OP_UP: begin
            w_frame_ok = (r_arg >= 8'h31) && (r_arg <= 8'h36);
            w_cmd_type = CMD_UP;
         end
         OP_DOWN: begin
            w_frame_ok = (r_arg >= 8'h32) && (r_arg <= 8'h37);
            w_cmd_type = CMD_DOWN;
         end
         OP_STAT: w_frame_ok = 1'b1;
         default: w_frame_ok = 1'b0;
      endcase
      w_frame_ok = w_frame_ok && (rx_data == CR);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (rx_valid) w_next = ST_GET_ARG;
         ST_GET_ARG:  if (w_timeout) w_next = ST_EXEC;
                      else if (rx_valid) w_next = ST_GET_TERM;
         ST_GET_TERM: if (w_timeout || rx_valid) w_next = ST_EXEC;
         ST_EXEC:     w_next = ST_REPLY;
         ST_REPLY:    if (!w_busy) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_arg       <= '0;
         r_tmo_cnt   <= '0;
         r_kind      <= RK_ERR;
         r_cmd_valid <= 1'b0;
         r_cmd_type  <= '0;
         r_cmd_floor <= '0;
      end else begin
         r_state     <= w_next;
         r_cmd_valid <= 1'b0;
         if (rx_valid || !w_in_frame)
            r_tmo_cnt <= '0;
         else if (!w_timeout)
            r_tmo_cnt <= r_tmo_cnt + 24'd1;

         if (r_state == ST_IDLE && rx_valid) r_op <= rx_data;
         if (r_state == ST_GET_ARG && !w_timeout && rx_valid) r_arg <= rx_data;

         // a byte landing on the timeout cycle is discarded
         if (w_timeout) begin
            r_kind <= RK_ERR;
         end else if (r_state == ST_GET_TERM && rx_valid) begin
            if (!w_frame_ok)
               r_kind <= RK_ERR;
            else if (r_op == OP_STAT)
               r_kind <= RK_STAT;
            else begin
               r_kind      <= RK_ACK;
               r_cmd_valid <= 1'b1;
               r_cmd_type  <= w_cmd_type;
               r_cmd_floor <= r_arg[2:0];
            end
         end
      end
   end

`ifdef UART_CMD_ERRCNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_err_cnt <= '0;
      else if (w_load && r_kind == RK_ERR && r_err_cnt != 8'hFF)
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign err_count = r_err_cnt;
`endif

   // cur_floor/cur_dir are sampled here, in the load cycle
   always_comb begin
      w_bytes = '0;
      w_len   = 3'd2;
      case (r_kind)
         RK_ACK: begin
            w_bytes[0] = ACK;
            w_bytes[1] = CR;
         end
         RK_STAT: begin
            w_bytes[0] = OP_STAT;
            w_bytes[1] = CH_0 + {5'd0, cur_floor};
            w_bytes[2] = dir_char(cur_dir);
`ifdef UART_CMD_ERRCNT_EN
            w_bytes[3] = (r_err_cnt != 8'd0) ? ERR : HEALTH_OK;
            w_bytes[4] = CR;
            w_len      = 3'd5;
`else
            w_bytes[3] = CR;
            w_len      = 3'd4;
`endif
         end
         default: begin
            w_bytes[0] = ERR;
            w_bytes[1] = CR;
         end
      endcase
   end

   uart_cmd_tx_seq u_tx_seq (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_bytes    (w_bytes),
      .i_len      (w_len),
      .i_tx_ready (tx_ready),
      .o_tx_data  (tx_data),
      .o_tx_en    (tx_en),
      .o_busy     (w_busy)
   );

   assign cmd_valid = r_cmd_valid;
   assign cmd_type  = r_cmd_type;
   assign cmd_floor = r_cmd_floor;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized frame bench for uart_cmd_responder with a frame-level reference model.
// Build with UART_CMD_ERRCNT_EN to cover the error counter variant.
module tb_uart_cmd_responder;
   localparam int CLKFRQ  = 100000;
   localparam int BAUD    = 10000;
   localparam int TOB     = 4;
   localparam int TMO     = (CLKFRQ / BAUD) * 10 * TOB;

   localparam byte unsigned B_C = 8'h43, B_U = 8'h55, B_D = 8'h44, B_S = 8'h53;
   localparam byte unsigned B_K = 8'h4B, B_E = 8'h45, B_I = 8'h49, B_O = 8'h4F;
   localparam byte unsigned B_CR = 8'h0D;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b1;
   logic [7:0] tx_data;
   logic       tx_en;
   logic [2:0] cur_floor = 3'd1;
   logic [1:0] cur_dir = 2'd0;
   logic       cmd_valid;
   logic [1:0] cmd_type;
   logic [2:0] cmd_floor;
`ifdef UART_CMD_ERRCNT_EN
   logic [7:0] err_count;
`endif

   uart_cmd_responder #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .TIMEOUT_BYTES(TOB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_en     (tx_en),
      .cur_floor (cur_floor),
      .cur_dir   (cur_dir),
      .cmd_valid (cmd_valid),
      .cmd_type  (cmd_type),
`ifdef UART_CMD_ERRCNT_EN
      .err_count (err_count),
`endif
      .cmd_floor (cmd_floor)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // sender model and output monitors, all sampled on the falling edge
   byte unsigned txq[$];
   int           txcycq[$];
   logic [4:0]   cmdq[$];
   int           cmdcycq[$];
   int           cyc = 0;
   int           busy_len = 3;
   int           busy_cnt = 0;
   int           proto_err = 0;
   logic         prev_en = 1'b0;
   logic         prev_cv = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (tx_en) begin
         if (!tx_ready || prev_en) proto_err++;
         txq.push_back(tx_data);
         txcycq.push_back(cyc);
         tx_ready = 1'b0;
         busy_cnt = busy_len;
      end else if (!tx_ready) begin
         if (busy_cnt <= 1) tx_ready = 1'b1;
         else busy_cnt--;
      end
      prev_en = tx_en;
      if (cmd_valid) begin
         if (prev_cv) proto_err++;
         cmdq.push_back({cmd_type, cmd_floor});
         cmdcycq.push_back(cyc);
      end
      prev_cv = cmd_valid;
   end

   int         err_model = 0;
   logic [4:0] last_cmd = '0;

   function automatic void ref_model(input byte unsigned op, input byte unsigned arg,
                                     input byte unsigned term, input bit tmo,
                                     input logic [2:0] fl, input logic [1:0] dir,
                                     output byte unsigned rep[$], output bit has_cmd,
                                     output logic [4:0] ecmd);
      int n;
      bit ok;
      int typ;
      n = int'(arg) - 48;
      ok = 1'b0;
      typ = 0;
      has_cmd = 1'b0;
      ecmd = '0;
      rep.delete();
      case (op)
         B_C: begin ok = (n >= 1 && n <= 7); typ = 0; end
         B_U: begin ok = (n >= 1 && n <= 6); typ = 1; end
         B_D: begin ok = (n >= 2 && n <= 7); typ = 2; end
         B_S: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      if (tmo || term != B_CR) ok = 1'b0;
      if (!ok) begin
         rep.push_back(B_E);
         rep.push_back(B_CR);
         if (err_model < 255) err_model++;
      end else if (op == B_S) begin
         rep.push_back(B_S);
         rep.push_back(8'(48 + int'(fl)));
         rep.push_back(dir == 2'd1 ? B_U : (dir == 2'd2 ? B_D : B_I));
`ifdef UART_CMD_ERRCNT_EN
         rep.push_back(err_model != 0 ? B_E : B_O);
`endif
         rep.push_back(B_CR);
      end else begin
         rep.push_back(B_K);
         rep.push_back(B_CR);
         has_cmd = 1'b1;
         ecmd = {2'(typ), 3'(n)};
      end
   endfunction

   task automatic send_byte(input byte unsigned b, output int scyc);
      @(posedge clk); #1;
      rx_data = b;
      rx_valid = 1'b1;
      scyc = cyc;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int bt, input int n, input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         if (txq.size() - bt >= n) break;
      end
   endtask

   task automatic check_reply(input int bt, input byte unsigned rep[$]);
      chk("reply_len", txq.size() - bt, rep.size());
      for (int i = 0; i < rep.size(); i++)
         if (bt + i < txq.size())
            chk($sformatf("reply_byte%0d", i), txq[bt+i], rep[i]);
   endtask

   task automatic check_cmd(input int bc, input bit has_cmd, input logic [4:0] ecmd,
                            input int exp_cyc);
      chk("cmd_count", cmdq.size() - bc, has_cmd);
      if (has_cmd && cmdq.size() > bc) begin
         chk("cmd_value", cmdq[bc], ecmd);
         chk("cmd_latency", cmdcycq[bc], exp_cyc);
         last_cmd = ecmd;
      end
      chk("cmd_hold", {cmd_type, cmd_floor}, last_cmd);
      chk("tx_cmd_protocol", proto_err, 0);
`ifdef UART_CMD_ERRCNT_EN
      chk("err_count", err_count, err_model);
`endif
   endtask

   task automatic run_frame(input byte unsigned op, input byte unsigned arg,
                            input byte unsigned term, input int gap_a, input int gap_t,
                            input bit inject);
      int bt, bc, s0, s2;
      byte unsigned rep[$];
      bit has_cmd;
      logic [4:0] ecmd;
      bt = txq.size();
      bc = cmdq.size();
      ref_model(op, arg, term, 1'b0, cur_floor, cur_dir, rep, has_cmd, ecmd);
      send_byte(op, s0);
      repeat (gap_a) @(posedge clk);
      send_byte(arg, s0);
      repeat (gap_t) @(posedge clk);
      send_byte(term, s2);
      if (inject) begin
         wait_tx(bt, 1, 3000);
         send_byte(B_C, s0);
         send_byte(8'h31, s0);
         send_byte(B_CR, s0);
      end
      wait_tx(bt, rep.size(), 3000);
      repeat (busy_len + 30) @(posedge clk);
      check_reply(bt, rep);
      check_cmd(bc, has_cmd, ecmd, s2 + 2);
   endtask

   task automatic run_timeout(input int nbytes);
      int bt, bc, s;
      byte unsigned rep[$];
      bit has_cmd;
      logic [4:0] ecmd;
      bt = txq.size();
      bc = cmdq.size();
      ref_model(B_C, 8'h33, B_CR, 1'b1, cur_floor, cur_dir, rep, has_cmd, ecmd);
      send_byte(B_C, s);
      if (nbytes == 2) send_byte(8'h33, s);
      wait_tx(bt, 2, TMO + 300);
      repeat (busy_len + 30) @(posedge clk);
      check_reply(bt, rep);
      check_cmd(bc, 1'b0, '0, 0);
      if (txcycq.size() > bt) chk("timeout_delay", txcycq[bt] - s, TMO + 5);
   endtask

   // OP, ARG, TERM boundary frames
   logic [23:0] bnd [0:10] = '{24'h43310D, 24'h43370D, 24'h43300D, 24'h43380D,
                               24'h55310D, 24'h55360D, 24'h44320D, 24'h44370D,
                               24'h43350A, 24'h58310D, 24'h53300A};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bt, s, found;
      logic [23:0] f;
      byte unsigned op, arg, term;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_data", tx_data, 8'hFF);
      chk("rst_tx_en", tx_en, 1'b0);
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_cmd_type", cmd_type, 2'd0);
      chk("rst_cmd_floor", cmd_floor, 3'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      busy_len = 3;
      run_frame(B_C, 8'h35, B_CR, 2, 2, 1'b0);
      busy_len = 5;
      run_frame(B_U, 8'h37, B_CR, 0, 0, 1'b0);
      run_frame(B_D, 8'h31, B_CR, 0, 0, 1'b0);
      cur_floor = 3'd3;
      cur_dir = 2'b10;
      run_frame(B_S, 8'h3F, B_CR, 1, 1, 1'b0);
      cur_floor = 3'd7;
      cur_dir = 2'b11;
      run_frame(B_S, 8'h30, B_CR, 0, 3, 1'b0);

      for (int k = 0; k < 11; k++) begin
         f = bnd[k];
         run_frame(f[23:16], f[15:8], f[7:0], 1, 1, 1'b0);
      end

      run_timeout(1);
      run_frame(B_C, 8'h32, B_CR, 300, 300, 1'b0);
      run_timeout(2);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 4))
            0: op = B_C;
            1: op = B_U;
            2: op = B_D;
            3: op = B_S;
            default: op = 8'($urandom);
         endcase
         arg  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(48 + $urandom_range(0, 9));
         term = ($urandom_range(0, 7) == 0) ? 8'($urandom) : B_CR;
         cur_floor = 3'($urandom_range(1, 7));
         cur_dir = 2'($urandom_range(0, 3));
         busy_len = $urandom_range(1, 20);
         run_frame(op, arg, term, $urandom_range(0, 30), $urandom_range(0, 30), 1'b0);
      end

      busy_len = 60;
      run_frame(B_C, 8'h36, B_CR, 1, 1, 1'b1);

      busy_len = 10;
      bt = txq.size();
      send_byte(B_C, s);
      send_byte(8'h33, s);
      send_byte(B_CR, s);
      found = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (tx_en && (txq.size() - bt == 1)) begin
            found = 1;
            break;
         end
      end
      chk("second_byte_seen", found, 1);
      reset = 1'b1;
      #1;
      chk("midreply_rst_tx_en", tx_en, 1'b0);
      chk("midreply_rst_tx_data", tx_data, 8'hFF);
      chk("midreply_rst_cmd_floor", cmd_floor, 3'd0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      err_model = 0;
      last_cmd = '0;
      bt = txq.size();
      repeat (60) @(posedge clk);
      chk("reply_abandoned", txq.size() - bt, 0);
      run_frame(B_C, 8'h34, B_CR, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
